// File: rtl/flit_base_delta_decomp_if.sv
// flit_base_delta_decomp_if: compressed-flit input and reconstructed-flit output handshakes
interface flit_base_delta_decomp_if #(parameter int OUTPUT_WIDTH = 128);
  logic in_valid;
  logic in_ready;
  logic raw_in;
  logic [OUTPUT_WIDTH-1:0] data_in;
  logic out_valid;
  logic out_ready;
  logic [OUTPUT_WIDTH-1:0] data_out;
  modport master (output in_valid, raw_in, data_in, out_ready, input in_ready, out_valid, data_out);
  modport slave (input in_valid, raw_in, data_in, out_ready, output in_ready, out_valid, data_out);
endinterface

// File: rtl/flit_base_delta_decomp.sv
// flit_base_delta_decomp: rebuilds min-base/delta compressed flits, LANES chunks per cycle
module flit_base_delta_decomp #(
  parameter int OUTPUT_WIDTH = 128,
  parameter int D = 8,
  parameter int DELTA_W = 4,
  parameter int LANES = 4
) (
  input logic clk_in,
  input logic rst_n_in,
  flit_base_delta_decomp_if.slave bus
);
  localparam int N = OUTPUT_WIDTH / D;
  localparam int STEPS = N / LANES;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [D-1:0] base;
  logic [N*DELTA_W-1:0] deltas;
  logic [OUTPUT_WIDTH-1:0] data_q;
  generate
    if (OUTPUT_WIDTH % D != 0 || N % LANES != 0 || D + N * DELTA_W > OUTPUT_WIDTH) begin : g_illegal
      $error("flit_base_delta_decomp: illegal parameter combination");
    end
  endgenerate
  // state register; reset drops any flit in flight
  always_ff @(posedge clk_in) state <= !rst_n_in ? IDLE : state_d;
  // next state: accept only in IDLE, expand STEPS cycles, hold until downstream takes it
  always_comb begin
    state_d = state;
    if (state == IDLE && bus.in_valid) state_d = bus.raw_in ? OUT : EXPAND;
    else if (state == EXPAND && cnt == CW'(STEPS - 1)) state_d = OUT;
    else if (state == OUT && bus.out_ready) state_d = IDLE;
  end
  // datapath: latch base/deltas on accept, then write LANES chunks per EXPAND cycle
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      base <= '0;
      deltas <= '0;
      data_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      cnt <= '0;
      base <= bus.data_in[D-1:0];
      deltas <= bus.data_in[D +: N*DELTA_W];
      if (bus.raw_in) data_q <= bus.data_in;
    end else if (state == EXPAND) begin
      cnt <= cnt + CW'(1);
      for (int j = 0; j < LANES; j++)
        data_q[(int'(cnt) * LANES + j) * D +: D] <= base + D'(deltas[(int'(cnt) * LANES + j) * DELTA_W +: DELTA_W]);
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == OUT;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_flit_base_delta_decomp.sv
// tb_flit_base_delta_decomp: randomized and directed checks against a byte-wise base+delta model
module tb_flit_base_delta_decomp;
  localparam int W = 128;
  logic clk_in = 0;
  logic rst_n_in = 0;
  int errors = 0;
  int checks = 0;
  flit_base_delta_decomp_if #(.OUTPUT_WIDTH(W)) bus();
  flit_base_delta_decomp #(.OUTPUT_WIDTH(W), .D(8), .DELTA_W(4), .LANES(4)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;

  function automatic logic [W-1:0] model(input logic raw, input logic [W-1:0] d);
    logic [W-1:0] r;
    if (raw) return d;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(d[7:0] + 8'(d[8 + 4*k +: 4]));
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input logic [7:0] b, input logic [63:0] dl, input logic [55:0] junk);
    return {junk, dl, b};
  endfunction

  task automatic xfer(input logic raw, input logic [W-1:0] d, input int bp,
                      output int lat, output logic [W-1:0] got, output int busy_bad, output int post_bad);
    lat = 0;
    busy_bad = 0;
    post_bad = 0;
    @(negedge clk_in);
    bus.in_valid = 1;
    bus.raw_in = raw;
    bus.data_in = d;
    bus.out_ready = (bp == 0);
    @(posedge clk_in);
    lat = 1;
    @(negedge clk_in);
    bus.in_valid = 0;
    bus.raw_in = 1'($urandom);
    bus.data_in = {$urandom, $urandom, $urandom, $urandom};
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) busy_bad++;
      @(posedge clk_in);
      lat++;
      @(negedge clk_in);
    end
    got = bus.data_out;
    if (bus.in_ready !== 1'b0) busy_bad++;
    repeat (bp) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (bus.out_valid !== 1'b1 || bus.data_out !== got || bus.in_ready !== 1'b0) busy_bad++;
    end
    bus.out_ready = 1;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.out_ready = 0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) post_bad++;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b data_out=%h want 0/0", bus.out_valid, bus.data_out);
    end
    rst_n_in = 1;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_uniform;
    int lat, bb, pb;
    logic [W-1:0] got;
    xfer(1'b0, pack(8'h10, 64'h0, 56'h0), 0, lat, got, bb, pb);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL uniform_lat: got %0d want 5", lat); end
    checks++;
    if (got !== 128'h1010_1010_1010_1010_1010_1010_1010_1010) begin
      errors++;
      $display("FAIL uniform_data: got %h want %h", got, 128'h1010_1010_1010_1010_1010_1010_1010_1010);
    end
    checks++;
    if (bb != 0 || pb != 0) begin errors++; $display("FAIL uniform_ready: busy_bad=%0d post_bad=%0d want 0/0", bb, pb); end
  endtask

  task automatic test_ramp;
    int lat, bb, pb;
    logic [W-1:0] got, d;
    logic [63:0] dl;
    for (int k = 0; k < 16; k++) dl[4*k +: 4] = 4'(k);
    d = pack(8'h20, dl, 56'hA5A5A5_5A5A5A_FF);
    xfer(1'b0, d, 0, lat, got, bb, pb);
    checks++;
    if (got !== 128'h2F2E2D2C2B2A29282726252423222120) begin
      errors++;
      $display("FAIL ramp_data: got %h want %h", got, 128'h2F2E2D2C2B2A29282726252423222120);
    end
    checks++;
    if (got !== model(1'b0, d)) begin errors++; $display("FAIL ramp_model: got %h want %h", got, model(1'b0, d)); end
  endtask

  task automatic test_wrap;
    int lat, bb, pb;
    logic [W-1:0] got;
    xfer(1'b0, pack(8'hFE, 64'hF000_0000_0000_0021, 56'h0), 0, lat, got, bb, pb);
    checks++;
    if (got !== 128'h0DFE_FEFE_FEFE_FEFE_FEFE_FEFE_FEFE_00FF) begin
      errors++;
      $display("FAIL wrap_data: got %h want %h", got, 128'h0DFE_FEFE_FEFE_FEFE_FEFE_FEFE_FEFE_00FF);
    end
  endtask

  task automatic test_raw_bypass;
    logic [W-1:0] d1, d2;
    d1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    d2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    @(negedge clk_in);
    bus.in_valid = 1;
    bus.raw_in = 1;
    bus.data_in = d1;
    bus.out_ready = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== d1) begin
      errors++;
      $display("FAIL raw_first: out_valid=%b data_out=%h want 1/%h", bus.out_valid, bus.data_out, d1);
    end
    bus.data_in = d2;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== d1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_hold: out_valid=%b in_ready=%b data_out=%h want 1/0/%h", bus.out_valid, bus.in_ready, bus.data_out, d1);
    end
    bus.out_ready = 1;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.data_out !== d1) begin
      errors++;
      $display("FAIL raw_handshake: out_valid=%b in_ready=%b data_out=%h want 0/1/%h", bus.out_valid, bus.in_ready, bus.data_out, d1);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== d2) begin
      errors++;
      $display("FAIL raw_second: out_valid=%b data_out=%h want 1/%h", bus.out_valid, bus.data_out, d2);
    end
    @(posedge clk_in);
    @(negedge clk_in);
    bus.out_ready = 0;
  endtask

  task automatic test_backpressure;
    int lat, bb, pb;
    logic [W-1:0] got, d;
    logic [63:0] dl;
    for (int k = 0; k < 16; k++) dl[4*k +: 4] = 4'(k);
    d = pack(8'h20, dl, 56'h0);
    xfer(1'b0, d, 10, lat, got, bb, pb);
    checks++;
    if (lat != 5 || got !== model(1'b0, d)) begin
      errors++;
      $display("FAIL bp_data: lat=%0d data=%h want 5/%h", lat, got, model(1'b0, d));
    end
    checks++;
    if (bb != 0) begin errors++; $display("FAIL bp_hold: unstable cycles=%0d want 0", bb); end
    checks++;
    if (pb != 0) begin errors++; $display("FAIL bp_single: post-handshake errors=%0d want 0", pb); end
  endtask

  task automatic test_reset_mid;
    int lat, bb, pb;
    logic [W-1:0] got;
    @(negedge clk_in);
    bus.in_valid = 1;
    bus.raw_in = 0;
    bus.data_in = pack(8'h33, 64'h1111_1111_1111_1111, 56'h0);
    @(posedge clk_in);
    @(negedge clk_in);
    bus.in_valid = 0;
    repeat (2) begin @(posedge clk_in); @(negedge clk_in); end
    rst_n_in = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b data_out=%h want 0/1/0", bus.out_valid, bus.in_ready, bus.data_out);
    end
    xfer(1'b0, pack(8'h10, 64'h0, 56'h0), 0, lat, got, bb, pb);
    checks++;
    if (lat != 5 || got !== 128'h1010_1010_1010_1010_1010_1010_1010_1010) begin
      errors++;
      $display("FAIL midreset_after: lat=%0d data=%h want 5/1010..10", lat, got);
    end
  endtask

  task automatic test_random;
    int lat, bb, pb, want_lat;
    logic [W-1:0] got, d;
    logic raw;
    for (int i = 0; i < 24; i++) begin
      raw = 1'($urandom_range(0, 2) == 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      xfer(raw, d, int'($urandom_range(0, 3)), lat, got, bb, pb);
      want_lat = raw ? 1 : 5;
      checks++;
      if (got !== model(raw, d) || lat != want_lat || bb != 0 || pb != 0) begin
        errors++;
        $display("FAIL random_%0d: raw=%b lat=%0d data=%h bad=%0d/%0d want lat=%0d data=%h", i, raw, lat, got, bb, pb, want_lat, model(raw, d));
      end
    end
  endtask

  initial begin
    bus.in_valid = 0;
    bus.raw_in = 0;
    bus.data_in = '0;
    bus.out_ready = 0;
    test_reset;
    test_uniform;
    test_ramp;
    test_wrap;
    test_raw_bypass;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
